led_activity_driver: RTL and testbench

- Converts single-cycle activity and error event pulses into human-visible LED patterns for the 10 green and 10 red board LEDs.
- Sits directly upstream of the LED output register stage and drives its next-state inputs.
- Provides per-LED pulse stretching, sticky error latching, a heartbeat on green LED 9, and a lamp-test sequence.

---
 rtl/led_activity_driver.sv | 218 +++++++++++++++++++++
 tb/tb_led_activity_driver.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_activity_driver.sv
// LED activity driver: turns single-cycle activity/error pulses into visible LED
// patterns. It stretches green pulses, latches red errors, drives a heartbeat on
// green LED 9 and runs a lamp-test sequence. Both LED outputs are registered.
module led_activity_driver #(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STRETCH_TICKS = 10,
    parameter int unsigned HB_TICKS      = 25,
    parameter bit          HB_EN         = 1'b1,
    parameter bit          STICKY_RED    = 1'b1,
    parameter int unsigned LT_TICKS      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] event_g,
    input  logic [9:0] event_r,
    input  logic       err_clear,
    input  logic       lamp_test,
    output logic [9:0] ledg_next,
    output logic [9:0] ledr_next,
    output logic       tick
);

    localparam int unsigned   PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    STRETCH_LD = 8'(STRETCH_TICKS);
    localparam logic [7:0]    HB_LAST    = 8'(HB_TICKS - 1);
    localparam logic [7:0]    LT_LAST    = 8'(LT_TICKS - 1);
    localparam logic [7:0]    WALK_LAST  = 8'd9;

    typedef enum logic [1:0] {
        StNormal,
        StAllOn,
        StWalk
    } state_e;

    logic [PW-1:0] presc_q;
    // Display step: the tick delayed by one cycle. An event that lands on a step
    // cycle reloads its counter (load wins), so it still gets the full stretch.
    logic          step_q;

    logic [9:0]    ev_g;
    logic [7:0]    cnt_g_q [10];
    logic [9:0]    green_lit;
    logic [9:0]    red_lit;

    logic [7:0]    hb_cnt_q;
    logic          hb_q;

    state_e        state_q, state_d;
    logic [7:0]    phase_q, phase_d;
    logic [9:0]    ledg_d, ledr_d;
    logic [9:0]    walk_onehot;

    assign tick = (presc_q == PRESC_LAST);

    // Prescaler: free-running 0..TICK_DIV-1, plus the delayed step strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            step_q  <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            step_q  <= tick;
        end
    end

    // LED 9 belongs to the heartbeat when enabled, so its activity input is dropped
    assign ev_g = HB_EN ? {1'b0, event_g[8:0]} : event_g;

    // Green stretch counters: event reloads, step decrements down to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 10; i++) cnt_g_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (ev_g[i]) begin
                    cnt_g_q[i] <= STRETCH_LD;
                end else if (step_q && (cnt_g_q[i] != 8'd0)) begin
                    cnt_g_q[i] <= cnt_g_q[i] - 8'd1;
                end
            end
        end
    end

    if (STICKY_RED) begin : g_sticky_red
        logic [9:0] sticky_q;

        // Sticky errors: clear applies first, so a same-cycle event survives it
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sticky_q <= '0;
            end else begin
                sticky_q <= (err_clear ? 10'h000 : sticky_q) | event_r;
            end
        end

        assign red_lit = sticky_q;
    end else begin : g_stretch_red
        logic [7:0] cnt_r_q [10];

        // Red stretch counters, same rules as green
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < 10; i++) cnt_r_q[i] <= 8'd0;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (event_r[i]) begin
                        cnt_r_q[i] <= STRETCH_LD;
                    end else if (step_q && (cnt_r_q[i] != 8'd0)) begin
                        cnt_r_q[i] <= cnt_r_q[i] - 8'd1;
                    end
                end
            end
        end

        // Red LED is lit while its counter is non-zero
        always_comb begin
            red_lit = '0;
            for (int i = 0; i < 10; i++) red_lit[i] = (cnt_r_q[i] != 8'd0);
        end
    end

    // Heartbeat: toggle every HB_TICKS steps, starting dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_cnt_q <= 8'd0;
            hb_q     <= 1'b0;
        end else if (step_q) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_q <= 8'd0;
                hb_q     <= ~hb_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + 8'd1;
            end
        end
    end

    // Green pattern shown in NORMAL
    always_comb begin
        green_lit = '0;
        for (int i = 0; i < 10; i++) green_lit[i] = (cnt_g_q[i] != 8'd0);
        if (HB_EN) green_lit[9] = hb_q;
    end

    // Lamp-test FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StNormal;
            phase_q <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Lamp-test next state: a pulse always restarts ALL_ON; phases move on steps only
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (lamp_test) begin
            state_d = StAllOn;
            phase_d = 8'd0;
        end else if (step_q) begin
            case (state_q)
                StAllOn: begin
                    if (phase_q == LT_LAST) begin
                        state_d = StWalk;
                        phase_d = 8'd0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                StWalk: begin
                    if (phase_q == WALK_LAST) begin
                        state_d = StNormal;
                        phase_d = 8'd0;
                    end else begin
                        phase_d = phase_q + 8'd1;
                    end
                end
                default: begin
                    state_d = StNormal;
                end
            endcase
        end
    end

    // Lamp-test output decode; underlying LED state keeps running in all states
    always_comb begin
        walk_onehot = 10'h001 << phase_q[3:0];
        case (state_q)
            StAllOn: begin
                ledg_d = 10'h3FF;
                ledr_d = 10'h3FF;
            end
            StWalk: begin
                ledg_d = walk_onehot;
                ledr_d = walk_onehot;
            end
            default: begin
                ledg_d = green_lit;
                ledr_d = red_lit;
            end
        endcase
    end

    // Output register feeding the LED output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledg_next <= '0;
            ledr_next <= '0;
        end else begin
            ledg_next <= ledg_d;
            ledr_next <= ledr_d;
        end
    end

endmodule

// File: tb/tb_led_activity_driver.sv
// Bench for led_activity_driver: directed steps plus random traffic, checked every
// cycle against a reference model that works in whole display ticks.
module tb_led_activity_driver;

    localparam int TD = 4;
    localparam int ST = 3;
    localparam int HB = 2;
    localparam int LT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] event_g = '0;
    logic [9:0] event_r = '0;
    logic       err_clear = 1'b0;
    logic       lamp_test = 1'b0;
    logic [9:0] ledg_next;
    logic [9:0] ledr_next;
    logic       tick;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release and the edge of each last event
    int edge_n;
    int g_last [10];
    int r_set [10];
    int r_clr;
    int lt_last;

    int lit, d, l2, idx, n_chg, chg0, chg1, found;
    logic prev9, injected;

    always #5 clk = ~clk;

    led_activity_driver #(
        .TICK_DIV      (TD),
        .STRETCH_TICKS (ST),
        .HB_TICKS      (HB),
        .HB_EN         (1'b1),
        .STICKY_RED    (1'b1),
        .LT_TICKS      (LT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .event_g   (event_g),
        .event_r   (event_r),
        .err_clear (err_clear),
        .lamp_test (lamp_test),
        .ledg_next (ledg_next),
        .ledr_next (ledr_next),
        .tick      (tick)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        edge_n = 0;
        r_clr = 0;
        lt_last = 0;
        for (int i = 0; i < 10; i++) begin
            g_last[i] = 0;
            r_set[i] = 0;
        end
    endtask

    // Display steps taken on edges 1..x: state advances once per TD edges,
    // the first time on edge TD+1.
    function automatic int steps(input int x);
        return (x >= 1) ? (x - 1) / TD : 0;
    endfunction

    // Expected display state after edge x (the output register shows it one edge later)
    task automatic model(input int x, output logic [9:0] g, output logic [9:0] r);
        int k;
        g = '0;
        r = '0;
        for (int i = 0; i < 9; i++)
            if (g_last[i] > 0 && (steps(x) - steps(g_last[i])) < ST) g[i] = 1'b1;
        g[9] = ((steps(x) / HB) % 2) == 1;
        for (int i = 0; i < 10; i++)
            if (r_set[i] > 0 && r_set[i] >= r_clr) r[i] = 1'b1;
        if (lt_last > 0) begin
            k = steps(x) - steps(lt_last);
            if (k < LT) begin
                g = 10'h3FF;
                r = 10'h3FF;
            end else if (k - LT < 10) begin
                g = 10'd1 << (k - LT);
                r = g;
            end
        end
    endtask

    // One clock: check outputs after the edge, record sampled inputs, drop pulses
    task automatic cycle();
        logic [9:0] eg, er;
        logic t_exp;
        @(posedge clk);
        edge_n++;
        #1;
        model(edge_n - 1, eg, er);
        t_exp = ((edge_n % TD) == (TD - 1));
        chk("ledg", ledg_next, eg);
        chk("ledr", ledr_next, er);
        chk("tick", {9'd0, tick}, {9'd0, t_exp});
        for (int i = 0; i < 10; i++) begin
            if (event_g[i]) g_last[i] = edge_n;
            if (event_r[i]) r_set[i] = edge_n;
        end
        if (err_clear) r_clr = edge_n;
        if (lamp_test) lt_last = edge_n;
        event_g = '0;
        event_r = '0;
        err_clear = 1'b0;
        lamp_test = 1'b0;
    endtask

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ledg", ledg_next, 10'h000);
        chk("reset_ledr", ledr_next, 10'h000);
        chk("reset_tick", {9'd0, tick}, 10'h000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("tick_cycle1", {9'd0, tick}, 10'h000);
        repeat (3) cycle();
        chk("first_tick", {9'd0, tick}, 10'h001);

        // Event one cycle after a tick: full 12-cycle stretch
        while (edge_n % TD != 0) cycle();
        event_g = 10'h001;
        cycle();
        lit = 0;
        repeat (16) begin
            cycle();
            if (ledg_next[0]) lit++;
        end
        chk("stretch_after_tick", 10'(lit), 10'd12);

        // Event coincident with a tick: shortest stretch
        while (edge_n % TD != TD - 1) cycle();
        chk("tick_phase", {9'd0, tick}, 10'h001);
        event_g = 10'h001;
        cycle();
        lit = 0;
        repeat (16) begin
            cycle();
            if (ledg_next[0]) lit++;
        end
        chk("stretch_on_tick", 10'(lit), 10'd9);

        // Retrigger LED 3; event_g[9] rides along and must be ignored
        event_g = 10'h208;
        cycle();
        repeat (5) cycle();
        event_g = 10'h208;
        cycle();
        l2 = edge_n;
        d = (TD + 1 - (l2 % TD)) % TD;
        if (d == 0) d = TD;
        lit = 0;
        repeat (16) begin
            cycle();
            if (ledg_next[3]) lit++;
        end
        chk("retrigger_len", 10'(lit), 10'((ST - 1) * TD + d));

        // Heartbeat period on green LED 9
        n_chg = 0;
        chg0 = 0;
        chg1 = 0;
        prev9 = ledg_next[9];
        repeat (40) begin
            if ($urandom_range(0, 3) == 0) event_g = 10'h200;
            cycle();
            if (ledg_next[9] !== prev9) begin
                if (n_chg == 0) chg0 = edge_n;
                if (n_chg == 1) chg1 = edge_n;
                n_chg++;
            end
            prev9 = ledg_next[9];
        end
        chk("hb_period", 10'(chg1 - chg0), 10'(HB * TD));

        // Sticky red and clear-with-set
        event_r = 10'h020;
        cycle();
        repeat (30) cycle();
        chk("sticky_hold", ledr_next, 10'h020);
        err_clear = 1'b1;
        event_r = 10'h004;
        cycle();
        cycle();
        chk("clear_and_set", ledr_next, 10'h004);

        // Lamp test: all on, walk 001..200, then NORMAL with a red event from WALK
        lamp_test = 1'b1;
        cycle();
        cycle();
        chk("lt_all_on_g", ledg_next, 10'h3FF);
        chk("lt_all_on_r", ledr_next, 10'h3FF);
        idx = 0;
        injected = 1'b0;
        for (int n = 0; n < 80 && idx < 10; n++) begin
            cycle();
            if (ledg_next === (10'd1 << idx) && ledr_next === ledg_next) idx++;
            if (idx == 2 && !injected) begin
                event_r = 10'h002;
                injected = 1'b1;
            end
        end
        chk("walk_steps", 10'(idx), 10'd10);
        repeat (6) cycle();
        chk("after_walk_r", ledr_next, 10'h006);

        // Restart mid-walk
        lamp_test = 1'b1;
        cycle();
        found = 0;
        for (int n = 0; n < 60 && found == 0; n++) begin
            cycle();
            if (ledg_next === 10'h008) found = 1;
        end
        chk("walk_reach", 10'(found), 10'd1);
        lamp_test = 1'b1;
        cycle();
        cycle();
        chk("lt_restart", ledg_next, 10'h3FF);

        // Asynchronous reset mid-lamp-test
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_g", ledg_next, 10'h000);
        chk("async_rst_r", ledr_next, 10'h000);
        chk("async_rst_t", {9'd0, tick}, 10'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 5) == 0) event_g = 10'($urandom);
            if ($urandom_range(0, 7) == 0) event_r = 10'($urandom) & 10'($urandom);
            err_clear = ($urandom_range(0, 11) == 0);
            lamp_test = ($urandom_range(0, 149) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
